// File: rtl/pe_window_gen_if.sv
// Handshake bundle between the pixel source, the window generator and the
// downstream PE stage: pixel stream in, packed 3x3x2 windows out.
interface pe_window_gen_if #(
   parameter int BIT_W = 8
);
   logic                    i_pix_valid;
   logic                    o_pix_ready;
   logic [2*BIT_W-1:0]      i_pix_data;
   logic                    o_win_valid;
   logic                    i_win_ready;
   logic [18*BIT_W-1:0]     o_win_data;
   logic                    o_frame_done;

   // Source/sink side: drives pixels and the downstream ready.
   modport master (
      output i_pix_valid, i_pix_data, i_win_ready,
      input  o_pix_ready, o_win_valid, o_win_data, o_frame_done
   );

   // Window generator side.
   modport slave (
      input  i_pix_valid, i_pix_data, i_win_ready,
      output o_pix_ready, o_win_valid, o_win_data, o_frame_done
   );
endinterface

// File: rtl/pe_window_gen.sv
// 3x3x2 sliding-window generator for the 2-channel convolution PE.
// Takes a raster-scan pixel stream, keeps the two previous rows in line
// buffers and emits one packed window per pixel once row>=2 and col>=2
// (valid convolution, no padding). Output is a single register stage whose
// ready feeds straight back to the pixel side, so a stalled window freezes
// the whole pipeline.
module pe_window_gen #(
   parameter int IMG_W = 8,
   parameter int IMG_H = 8,
   parameter int BIT_W = 8
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   pe_window_gen_if.slave bus
);
   localparam int PIX_W = 2 * BIT_W;
   localparam int WIN_W = 18 * BIT_W;
   localparam int CW    = $clog2(IMG_W);
   localparam int RW    = $clog2(IMG_H);

   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   typedef logic [PIX_W-1:0] pix_t;

   logic [CW-1:0]    col;
   logic [RW-1:0]    row;
   pix_t             lb0 [IMG_W];   // row r-1
   pix_t             lb1 [IMG_W];   // row r-2
   pix_t             win [3][3];    // [row][col], row 0 / col 0 oldest
   pix_t             nxt [3][3];
   logic [WIN_W-1:0] new_data;
   logic             win_valid;
   logic [WIN_W-1:0] win_data;
   logic             frame_done;
   logic             pix_ready;
   logic             acc;
   logic             emit;
   logic             last_pix;

   // Ready is purely a function of the output stage: no skid buffer.
   assign pix_ready = ~win_valid | bus.i_win_ready;
   assign acc       = bus.i_pix_valid & pix_ready;
   assign emit      = acc && (row >= RW'(2)) && (col >= CW'(2));
   assign last_pix  = (row == ROW_LAST) && (col == COL_LAST);

   assign bus.o_pix_ready  = pix_ready;
   assign bus.o_win_valid  = win_valid;
   assign bus.o_win_data   = win_data;
   assign bus.o_frame_done = frame_done;

   // Raster position of the pixel currently offered; wraps straight into the next frame.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
      if (!i_rst_n) begin
         col <= '0;
         row <= '0;
      end else if (acc) begin
         if (col == COL_LAST) begin
            col <= '0;
            row <= (row == ROW_LAST) ? '0 : row + RW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end
   end

   // Two-row line buffers: the column slot ages one row per accepted pixel.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      // NOTE: the buffers are flop arrays cleared by reset; a RAM macro would need this reset removed.
      if (!i_rst_n) begin
         for (int i = 0; i < IMG_W; i++) begin
            lb0[i] <= '0;
            lb1[i] <= '0;
         end
      end else if (acc) begin
         lb1[col] <= lb0[col];
         lb0[col] <= bus.i_pix_data;
      end
   end

   // Next window: shift columns left, new column from {lb1, lb0, incoming pixel}.
   always_comb begin
      // NOTE: every element is assigned on every pass, so no latch can be inferred.
      for (int r = 0; r < 3; r++) begin
         nxt[r][0] = win[r][1];
         nxt[r][1] = win[r][2];
      end
      nxt[0][2] = lb1[col];
      nxt[1][2] = lb0[col];
      nxt[2][2] = bus.i_pix_data;
   end

   // Pack channel-major, then row, then column, MSB first; samples pass through untouched.
   always_comb begin
      new_data = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            new_data[WIN_W-1-BIT_W*(r*3+c) -: BIT_W]     = nxt[r][c][PIX_W-1 -: BIT_W];
            new_data[WIN_W-1-BIT_W*(9+r*3+c) -: BIT_W]   = nxt[r][c][BIT_W-1:0];
         end
      end
   end

   // Window shift register advances on every accepted pixel, emitted or not.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               win[r][c] <= '0;
            end
         end
      end else if (acc) begin
         win <= nxt;
      end
   end

   // Output stage: a new window replaces the old one in the same cycle it is taken.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         win_valid  <= 1'b0;
         win_data   <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= acc && last_pix;
         if (emit) begin
            win_valid <= 1'b1;
            win_data  <= new_data;
         end else if (bus.i_win_ready) begin
            win_valid <= 1'b0;
         end
      end
   end
endmodule

// File: doc/pe_window_gen.md
Name: pe_window_gen

Overview:
- Upstream feeder for the 2-channel 3x3 convolution PE.
- Accepts a raster-scan stream of 2-channel 8-bit signed pixels.
- Buffers two previous rows in line buffers, forms 3x3x2 windows, and presents each window as one 144-bit word in the PE's image-operand packing order.
- Valid convolution only: no padding. Each frame yields (IMG_H-2)*(IMG_W-2) windows, and the downstream handshake applies backpressure.

Parameters:
- IMG_W, 8, pixels per row; legal range 3..256.
- IMG_H, 8, rows per frame; legal range 3..256.
- BIT_W, 8, bits per channel sample.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_pix_valid  in  1  input pixel valid
- o_pix_ready  out  1  block can accept a pixel this cycle
- i_pix_data  in  16  {ch0[15:8], ch1[7:0]}, two's complement
- o_win_valid  out  1  o_win_data holds a complete window
- i_win_ready  in  1  downstream (PE stage) accepts window
- o_win_data  out  144  packed 3x3x2 window
- o_frame_done  out  1  one-cycle pulse, last pixel of frame accepted

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous, active-low; all state flops clear on its assertion.
- Reset values:
  - o_win_valid=0, o_win_data=0, o_frame_done=0.
  - Column and row counters = 0.
  - Line buffers and window registers = 0.
  - o_pix_ready=1 once reset is released.
- Pixel accept: acc = i_pix_valid & o_pix_ready.
- Ready rule: o_pix_ready = ~o_win_valid | i_win_ready. This is combinational and has no skid buffer; ready never depends on i_pix_valid.
- Counters:
  - col runs 0..IMG_W-1 and row runs 0..IMG_H-1, advancing only on acc.
  - At col=IMG_W-1, col wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1), both wrap to 0 and the next frame begins with no idle cycle.
- Line buffers: lb1 holds row r-2 and lb0 holds row r-1, each IMG_W x 16 bits. On acc at column c: lb1[c] <= lb0[c], lb0[c] <= i_pix_data.
- Window register: a 3 rows x 3 cols x 2 ch array. On acc, columns shift left (col0 <= col1, col1 <= col2) and the new col2 loads {lb1[c], lb0[c], i_pix_data} as rows 0, 1, 2. Row 0 is the oldest row; col 0 is the oldest column.
- Window emit condition: acc with row>=2 and col>=2, evaluated on pre-increment counters. Windows formed with col<2 contain stale data from the previous row and are never emitted.
- Latency: o_win_valid rises on the clock edge after the completing pixel is accepted, and o_win_data reflects that pixel in the same cycle.
- Output register update, per cycle:
  - emit: o_win_valid<=1, o_win_data<=new window.
  - else if i_win_ready: o_win_valid<=0.
  - else: hold valid and data.
- Simultaneous events: a downstream accept and a new emit in the same cycle are legal; the new window replaces the old one with no bubble. Throughput is 1 pixel/cycle and 1 window/cycle.
- Backpressure: while o_win_valid=1 and i_win_ready=0, o_pix_ready=0. Counters, line buffers and o_win_data are held stable.
- Packing of o_win_data, MSB first, 8 bits per element, channel then row then column:
  - ch0 r0c0 in bits [143:136], ch0 r0c1, ch0 r0c2, ch0 r1c0 … ch0 r2c2.
  - Then ch1 r0c0 … ch1 r2c2, ending with ch1 r2c2 in bits [7:0].
  - Samples are passed through unchanged; no arithmetic or sign extension.
- o_frame_done: pulses high for exactly one cycle, on the edge after acc at (IMG_H-1, IMG_W-1). This coincides with o_win_valid rising for the final window.
- Reset mid-frame: counters return to (0,0) and any pending window is dropped. Line buffer contents are don't-care, because the first emit of a new frame requires row>=2, which refills both buffers.

Test Plan:
- IMG_W=IMG_H=4, ch0=k (pixel index 0..15), ch1=0x80|k, i_win_ready=1, valid every cycle → exactly 4 windows, emitted after k=10, 11, 14, 15. The first window's ch0 bytes are 00 01 02 04 05 06 08 09 0A and its ch1 bytes are 80 81 82 84 85 86 88 89 8A. o_frame_done pulses once, with the 4th window.
- Same stream with i_win_ready=0 for 5 cycles after the first window → o_pix_ready=0 during the stall, o_win_data is stable, no pixel is lost, and the 2nd window is ch0 01 02 03 05 06 07 09 0A 0B.
- Two back-to-back frames (second frame ch0=0x40+k) → 8 windows total. The second frame's first window is ch0 40 41 42 44 45 46 48 49 4A, with no first-frame data in it.
- Random i_pix_valid gaps (about 30%) and random i_win_ready on a 4x4 frame → window sequence identical to the gap-free run, and no window emitted for col<2.
- Assert i_rst_n low after 7 pixels, then send a fresh 4x4 frame → o_win_valid=0 and o_win_data=0 during reset, and output matches the first scenario exactly.
- Default parameters 8x8, signed extremes (ch0=0x7F, ch1=0x80 for all pixels) → 36 windows, every byte passed through unchanged.
